// File: rtl/sevenseg_frame_scheduler_if.sv
// Write-request channel for the seven-segment frame scheduler: CPU and debug requesters,
// each with a request/slot/data bundle and a one-cycle grant back from the scheduler.
interface sevenseg_frame_scheduler_if;
  logic        i_CPU_REQ;
  logic [1:0]  i_CPU_SLOT;
  logic [15:0] i_CPU_DATA;
  logic        o_CPU_GNT;
  logic        i_DBG_REQ;
  logic [1:0]  i_DBG_SLOT;
  logic [15:0] i_DBG_DATA;
  logic        o_DBG_GNT;

  modport master (
    output i_CPU_REQ, i_CPU_SLOT, i_CPU_DATA,
    output i_DBG_REQ, i_DBG_SLOT, i_DBG_DATA,
    input  o_CPU_GNT, o_DBG_GNT
  );

  modport slave (
    input  i_CPU_REQ, i_CPU_SLOT, i_CPU_DATA,
    input  i_DBG_REQ, i_DBG_SLOT, i_DBG_DATA,
    output o_CPU_GNT, o_DBG_GNT
  );
endinterface

// File: rtl/sevenseg_frame_scheduler.sv
// Round-robin CPU/debug writes into a shadow of four 16-bit words, committed to the serializer
// once per frame at a safe position. Define SEVSEG_BLANK_EN to add the i_BLANK override.
module sevenseg_frame_scheduler #(
  parameter int unsigned FRAME_LEN      = 64,
  parameter int unsigned COMMIT_POS     = 32,
  parameter int unsigned SER_RST_CYCLES = 2
`ifdef SEVSEG_BLANK_EN
  ,
  parameter logic [15:0] BLANK_WORD     = 16'h0000
`endif
) (
  input  logic                      i_CLK,
  input  logic                      i_RESET_N,
`ifdef SEVSEG_BLANK_EN
  input  logic                      i_BLANK,
`endif
  sevenseg_frame_scheduler_if.slave wr_if,
  output logic [15:0]               o_7SegData16_0,
  output logic [15:0]               o_7SegData16_1,
  output logic [15:0]               o_7SegData16_2,
  output logic [15:0]               o_7SegData16_3,
  output logic                      o_SER_RESET,
  output logic                      o_PENDING,
  output logic [7:0]                o_FRAME_CNT
);

  localparam int unsigned PosW = $clog2(FRAME_LEN);
  localparam int unsigned CntW = $clog2(SER_RST_CYCLES + 1);
  localparam logic [PosW-1:0] PosLast   = PosW'(FRAME_LEN - 1);
  localparam logic [PosW-1:0] PosCommit = PosW'(COMMIT_POS - 1);
  localparam logic [CntW-1:0] CntLast   = CntW'(SER_RST_CYCLES - 1);

  typedef enum logic [0:0] {StHold, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PosW-1:0]   pos_q, pos_d;
  logic [7:0]        frame_q, frame_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              dbg_gnt_q, dbg_gnt_d;
  logic              last_cpu_q, last_cpu_d;
  logic              pending_q, pending_d;
  logic [3:0][15:0]  shadow_q, shadow_d;
  logic [3:0][15:0]  active_q, active_d;
  logic              run;
  logic              commit_pt;
  logic              commit;

  // FSM state register
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q <= StHold;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: hold the serializer in reset for SER_RST_CYCLES clocks, then run forever
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StHold: begin
        if (cnt_q == CntLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: cnt_d = '0;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_SER_RESET = (state_q == StHold);
    run         = (state_q == StRun);
  end

  always_comb begin
    commit_pt = run && (pos_q == PosCommit);
    commit    = commit_pt && pending_q;

    pos_d   = '0;
    frame_d = frame_q;
    if (run) begin
      if (pos_q == PosLast) begin
        frame_d = frame_q + 8'd1;
      end else begin
        pos_d = pos_q + 1'b1;
      end
    end

    // On a tie, the requester that was not granted last wins
    cpu_gnt_d  = wr_if.i_CPU_REQ && (!wr_if.i_DBG_REQ || !last_cpu_q);
    dbg_gnt_d  = wr_if.i_DBG_REQ && !cpu_gnt_d;
    last_cpu_d = last_cpu_q;
    if (cpu_gnt_d) begin
      last_cpu_d = 1'b1;
    end else if (dbg_gnt_d) begin
      last_cpu_d = 1'b0;
    end

    shadow_d = shadow_q;
    if (cpu_gnt_d) begin
      shadow_d[wr_if.i_CPU_SLOT] = wr_if.i_CPU_DATA;
    end else if (dbg_gnt_d) begin
      shadow_d[wr_if.i_DBG_SLOT] = wr_if.i_DBG_DATA;
    end

    // A write landing on the commit edge stays pending for the next frame
    pending_d = pending_q;
    if (cpu_gnt_d || dbg_gnt_d) begin
      pending_d = 1'b1;
    end else if (commit) begin
      pending_d = 1'b0;
    end

    active_d = commit ? shadow_q : active_q;
  end

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      pos_q      <= '0;
      frame_q    <= '0;
      cpu_gnt_q  <= 1'b0;
      dbg_gnt_q  <= 1'b0;
      last_cpu_q <= 1'b1;
      pending_q  <= 1'b0;
      shadow_q   <= '0;
      active_q   <= '0;
    end else begin
      pos_q      <= pos_d;
      frame_q    <= frame_d;
      cpu_gnt_q  <= cpu_gnt_d;
      dbg_gnt_q  <= dbg_gnt_d;
      last_cpu_q <= last_cpu_d;
      pending_q  <= pending_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
    end
  end

  assign wr_if.o_CPU_GNT = cpu_gnt_q;
  assign wr_if.o_DBG_GNT = dbg_gnt_q;
  assign o_PENDING       = pending_q;
  assign o_FRAME_CNT     = frame_q;

`ifdef SEVSEG_BLANK_EN
  logic blank_q, blank_d;

  // Blank request is sampled only at the commit point so the outputs obey the same stability
  assign blank_d = commit_pt ? i_BLANK : blank_q;

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      blank_q <= 1'b0;
    end else begin
      blank_q <= blank_d;
    end
  end

  always_comb begin
    o_7SegData16_0 = blank_q ? BLANK_WORD : active_q[0];
    o_7SegData16_1 = blank_q ? BLANK_WORD : active_q[1];
    o_7SegData16_2 = blank_q ? BLANK_WORD : active_q[2];
    o_7SegData16_3 = blank_q ? BLANK_WORD : active_q[3];
  end
`else
  always_comb begin
    o_7SegData16_0 = active_q[0];
    o_7SegData16_1 = active_q[1];
    o_7SegData16_2 = active_q[2];
    o_7SegData16_3 = active_q[3];
  end
`endif

endmodule

// File: tb/tb_sevenseg_frame_scheduler.sv
// Directed bench for sevenseg_frame_scheduler: arbitration table plus commit, reset,
// blanking and frame-counter sequences against a small position/shadow model.
module tb_sevenseg_frame_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] d0, d1, d2, d3;
  logic        ser_rst;
  logic        pending;
  logic [7:0]  frame_cnt;
`ifdef SEVSEG_BLANK_EN
  logic        blank;
`endif

  sevenseg_frame_scheduler_if wr_if ();

  sevenseg_frame_scheduler #(
    .FRAME_LEN      (64),
    .COMMIT_POS     (32),
    .SER_RST_CYCLES (2)
`ifdef SEVSEG_BLANK_EN
    ,
    .BLANK_WORD     (16'hFFFF)
`endif
  ) dut (
    .i_CLK          (clk),
    .i_RESET_N      (rst_n),
`ifdef SEVSEG_BLANK_EN
    .i_BLANK        (blank),
`endif
    .wr_if          (wr_if),
    .o_7SegData16_0 (d0),
    .o_7SegData16_1 (d1),
    .o_7SegData16_2 (d2),
    .o_7SegData16_3 (d3),
    .o_SER_RESET    (ser_rst),
    .o_PENDING      (pending),
    .o_FRAME_CNT    (frame_cnt)
  );

  typedef struct {
    logic        cpu_req;
    logic [1:0]  cpu_slot;
    logic [15:0] cpu_data;
    logic        dbg_req;
    logic [1:0]  dbg_slot;
    logic [15:0] dbg_data;
    logic        exp_cpu;
    logic        exp_dbg;
  } vec_t;

  vec_t        vecs [10];
  int          n_tests  = 0;
  int          n_fail   = 0;
  int          tb_pos   = 0;
  int          tb_frame = 0;
  bit          tb_run   = 1'b0;
  logic [15:0] exp_sh  [4];
  logic [15:0] exp_act [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (tb_run) begin
      if (tb_pos == 63) tb_frame = (tb_frame + 1) % 256;
      tb_pos = (tb_pos + 1) % 64;
    end
  endtask

  task automatic goto_pos(input int p);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (tb_pos != p && n < 70);
  endtask

  task automatic idle_reqs();
    wr_if.i_CPU_REQ = 1'b0;
    wr_if.i_DBG_REQ = 1'b0;
  endtask

  task automatic check_slots(input string name, input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3);
    chk({name, "_slot0"}, {16'h0, d0}, {16'h0, e0});
    chk({name, "_slot1"}, {16'h0, d1}, {16'h0, e1});
    chk({name, "_slot2"}, {16'h0, d2}, {16'h0, e2});
    chk({name, "_slot3"}, {16'h0, d3}, {16'h0, e3});
  endtask

  task automatic release_seq(input string name);
    rst_n = 1'b1;
    tick();
    chk({name, "_ser_rst_edge1"}, 32'(ser_rst), 32'd1);
    tick();
    chk({name, "_ser_rst_edge2"}, 32'(ser_rst), 32'd0);
    tb_run = 1'b1;
    tb_pos = 0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'd0, 16'h0101, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 2'd0, 16'h0000, 1'b1, 2'd1, 16'h0202, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 2'd2, 16'h0303, 1'b1, 2'd3, 16'h0404, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 2'd2, 16'h0505, 1'b1, 2'd3, 16'h0606, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 2'd0, 16'h0707, 1'b1, 2'd1, 16'h0808, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 2'd1, 16'h0909, 1'b1, 2'd1, 16'h0A0A, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 2'd0, 16'h0000, 1'b1, 2'd2, 16'h0B0B, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 2'd3, 16'h0C0C, 1'b1, 2'd0, 16'h0D0D, 1'b1, 1'b0};

    for (int i = 0; i < 4; i++) begin
      exp_sh[i]  = 16'h0;
      exp_act[i] = 16'h0;
    end
    rst_n            = 1'b0;
    wr_if.i_CPU_SLOT = 2'd0;
    wr_if.i_CPU_DATA = 16'h0;
    wr_if.i_DBG_SLOT = 2'd0;
    wr_if.i_DBG_DATA = 16'h0;
    idle_reqs();
`ifdef SEVSEG_BLANK_EN
    blank = 1'b0;
`endif

    // Reset state
    repeat (3) tick();
    check_slots("rst", 16'h0, 16'h0, 16'h0, 16'h0);
    chk("rst_ser_reset", 32'(ser_rst), 32'd1);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_cpu_gnt", 32'(wr_if.o_CPU_GNT), 32'd0);
    chk("rst_dbg_gnt", 32'(wr_if.o_DBG_GNT), 32'd0);
    release_seq("rel");

    // CPU write slot 2 at position 5, committed at 31->32
    goto_pos(5);
    wr_if.i_CPU_REQ  = 1'b1;
    wr_if.i_CPU_SLOT = 2'd2;
    wr_if.i_CPU_DATA = 16'hA5C3;
    tick();
    chk("a_cpu_gnt", 32'(wr_if.o_CPU_GNT), 32'd1);
    chk("a_dbg_gnt", 32'(wr_if.o_DBG_GNT), 32'd0);
    chk("a_pending", 32'(pending), 32'd1);
    exp_sh[2] = 16'hA5C3;
    idle_reqs();
    tick();
    chk("a_gnt_one_cycle", 32'(wr_if.o_CPU_GNT), 32'd0);
    goto_pos(31);
    chk("a_pre_commit_slot2", 32'(d2), 32'd0);
    chk("a_pre_commit_pending", 32'(pending), 32'd1);
    tick();
    exp_act = exp_sh;
    check_slots("a_commit", exp_act[0], exp_act[1], exp_act[2], exp_act[3]);
    chk("a_post_pending", 32'(pending), 32'd0);

    // Arbitration table, one edge per vector
    for (int i = 0; i < 10; i++) begin
      wr_if.i_CPU_REQ  = vecs[i].cpu_req;
      wr_if.i_CPU_SLOT = vecs[i].cpu_slot;
      wr_if.i_CPU_DATA = vecs[i].cpu_data;
      wr_if.i_DBG_REQ  = vecs[i].dbg_req;
      wr_if.i_DBG_SLOT = vecs[i].dbg_slot;
      wr_if.i_DBG_DATA = vecs[i].dbg_data;
      tick();
      chk($sformatf("tbl%0d_cpu_gnt", i), 32'(wr_if.o_CPU_GNT), 32'(vecs[i].exp_cpu));
      chk($sformatf("tbl%0d_dbg_gnt", i), 32'(wr_if.o_DBG_GNT), 32'(vecs[i].exp_dbg));
      if (vecs[i].exp_cpu) exp_sh[vecs[i].cpu_slot] = vecs[i].cpu_data;
      if (vecs[i].exp_dbg) exp_sh[vecs[i].dbg_slot] = vecs[i].dbg_data;
    end
    idle_reqs();
    check_slots("tbl_no_early_commit", exp_act[0], exp_act[1], exp_act[2], exp_act[3]);
    goto_pos(32);
    exp_act = exp_sh;
    check_slots("tbl_commit", exp_act[0], exp_act[1], exp_act[2], exp_act[3]);

    // Continuous contention on slot 0: DBG, CPU, DBG, CPU, DBG
    wr_if.i_CPU_REQ  = 1'b1;
    wr_if.i_CPU_SLOT = 2'd0;
    wr_if.i_CPU_DATA = 16'h1111;
    wr_if.i_DBG_REQ  = 1'b1;
    wr_if.i_DBG_SLOT = 2'd0;
    wr_if.i_DBG_DATA = 16'h2222;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rr%0d_dbg_gnt", i), 32'(wr_if.o_DBG_GNT), 32'((i % 2) == 0));
      chk($sformatf("rr%0d_cpu_gnt", i), 32'(wr_if.o_CPU_GNT), 32'((i % 2) == 1));
    end
    idle_reqs();
    exp_sh[0] = 16'h2222;
    goto_pos(32);
    exp_act = exp_sh;
    check_slots("rr_commit", exp_act[0], exp_act[1], exp_act[2], exp_act[3]);

    // Write granted on the commit edge lands in shadow only
    goto_pos(10);
    wr_if.i_CPU_REQ  = 1'b1;
    wr_if.i_CPU_SLOT = 2'd1;
    wr_if.i_CPU_DATA = 16'hBEEF;
    tick();
    chk("c_first_gnt", 32'(wr_if.o_CPU_GNT), 32'd1);
    idle_reqs();
    exp_sh[1] = 16'hBEEF;
    goto_pos(31);
    wr_if.i_CPU_REQ  = 1'b1;
    wr_if.i_CPU_DATA = 16'hCAFE;
    tick();
    idle_reqs();
    chk("c_edge_gnt", 32'(wr_if.o_CPU_GNT), 32'd1);
    exp_act   = exp_sh;
    exp_sh[1] = 16'hCAFE;
    check_slots("c_old_shadow", exp_act[0], exp_act[1], exp_act[2], exp_act[3]);
    chk("c_pending_kept", 32'(pending), 32'd1);
    goto_pos(31);
    chk("c_pending_frame", 32'(pending), 32'd1);
    tick();
    exp_act = exp_sh;
    check_slots("c_next_frame", exp_act[0], exp_act[1], exp_act[2], exp_act[3]);
    chk("c_pending_clear", 32'(pending), 32'd0);

`ifdef SEVSEG_BLANK_EN
    goto_pos(20);
    blank = 1'b1;
    goto_pos(31);
    check_slots("blk_before", exp_act[0], exp_act[1], exp_act[2], exp_act[3]);
    tick();
    check_slots("blk_on", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    blank = 1'b0;
    goto_pos(31);
    check_slots("blk_hold", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    tick();
    check_slots("blk_off", exp_act[0], exp_act[1], exp_act[2], exp_act[3]);
`endif

    // Async reset at position 40 with a pending write
    goto_pos(35);
    wr_if.i_DBG_REQ  = 1'b1;
    wr_if.i_DBG_SLOT = 2'd3;
    wr_if.i_DBG_DATA = 16'h1234;
    tick();
    idle_reqs();
    chk("d_dbg_gnt", 32'(wr_if.o_DBG_GNT), 32'd1);
    chk("d_pending", 32'(pending), 32'd1);
    goto_pos(40);
    #2;
    rst_n = 1'b0;
    #1;
    check_slots("d_async", 16'h0, 16'h0, 16'h0, 16'h0);
    chk("d_async_pending", 32'(pending), 32'd0);
    chk("d_async_ser_rst", 32'(ser_rst), 32'd1);
    chk("d_async_frame", 32'(frame_cnt), 32'd0);
    chk("d_async_gnt", 32'(wr_if.o_DBG_GNT), 32'd0);
    tb_run   = 1'b0;
    tb_frame = 0;
    for (int i = 0; i < 4; i++) begin
      exp_sh[i]  = 16'h0;
      exp_act[i] = 16'h0;
    end
    tick();
    release_seq("d_rel");
    goto_pos(33);
    check_slots("d_no_commit", 16'h0, 16'h0, 16'h0, 16'h0);
    chk("d_no_pending", 32'(pending), 32'd0);

    // Frame counter wraps 255 -> 0
    chk("e_frame_start", 32'(frame_cnt), 32'(tb_frame));
    goto_pos(0);
    chk("e_frame_one", 32'(frame_cnt), 32'(tb_frame));
    repeat (254 * 64) tick();
    chk("e_frame_255", 32'(frame_cnt), 32'(tb_frame));
    repeat (64) tick();
    chk("e_frame_wrap", 32'(frame_cnt), 32'(tb_frame));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
